// File: rtl/latch_bank_reader.sv
// latch_bank_reader
// Flop-based read port in front of a latch-based storage bank. A read request
// drives the bank read address, then waits until the bank gate has been closed
// for SETTLE consecutive cycles before sampling the bank data. The captured
// value is returned on a valid/ready response channel. If the gate stays open
// for MAX_WAIT consecutive cycles, the read is abandoned and an error response
// is returned instead.
//
// Ports
//   clk            rising-edge clock
//   rst            synchronous active-high reset
//   req_valid      read request valid
//   req_ready      block is idle and can accept a request
//   req_addr       entry to read (sampled at the accept edge only)
//   bank_gate      1 = some latch entry is transparent
//   bank_rd_addr   address to the bank read mux, held for the whole read
//   bank_rd_data   combinational bank read data
//   rsp_valid      response valid
//   rsp_ready      consumer accepts the response
//   rsp_data       captured data (0 on error)
//   rsp_err        read abandoned because the gate stayed open too long
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for a request; req_ready=1
// SETUP | address driven; counting closed-gate cycles before capture
// RESP  | response presented; waiting for rsp_ready

module latch_bank_reader #(
    parameter int ADDR_W   = 4,
    parameter int DATA_W   = 8,
    parameter int SETTLE   = 2,
    parameter int MAX_WAIT = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic              bank_gate,
    output logic [ADDR_W-1:0] bank_rd_addr,
    input  logic [DATA_W-1:0] bank_rd_data,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_err
);

    // cnt must hold SETTLE; wcnt must hold MAX_WAIT-1 (at least one bit).
    localparam int CNT_W  = $clog2(SETTLE + 1);
    localparam int WCNT_W = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;

    localparam logic [CNT_W-1:0]  CNT_LOAD  = CNT_W'(SETTLE);
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
    localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(MAX_WAIT - 1);
    localparam logic [WCNT_W-1:0] WCNT_ONE  = WCNT_W'(1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SETUP = 2'd1;
    localparam logic [1:0] S_RESP  = 2'd2;

    logic [1:0]        state;
    logic [CNT_W-1:0]  cnt;
    logic [WCNT_W-1:0] wcnt;

    assign req_ready = (state == S_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            cnt          <= '0;
            wcnt         <= '0;
            bank_rd_addr <= '0;
            rsp_valid    <= 1'b0;
            rsp_data     <= '0;
            rsp_err      <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        bank_rd_addr <= req_addr;
                        cnt          <= CNT_LOAD;
                        wcnt         <= '0;
                        state        <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    // An open gate always wins over a pending capture: the
                    // latch may be changing, so the settle window restarts.
                    if (bank_gate && (wcnt == WCNT_LAST)) begin
                        rsp_data  <= '0;
                        rsp_err   <= 1'b1;
                        rsp_valid <= 1'b1;
                        state     <= S_RESP;
                    end else if (bank_gate) begin
                        cnt  <= CNT_LOAD;
                        wcnt <= wcnt + WCNT_ONE;
                    end else if (cnt == CNT_ONE) begin
                        rsp_data  <= bank_rd_data;
                        rsp_err   <= 1'b0;
                        rsp_valid <= 1'b1;
                        wcnt      <= '0;
                        state     <= S_RESP;
                    end else begin
                        cnt  <= cnt - CNT_ONE;
                        wcnt <= '0;
                    end
                end
                S_RESP: begin
                    // rsp_data/rsp_err keep their last values after the handshake.
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
